score_tracker: RTL and testbench

- Response end of the game FSM's scoring interface.
- Consumes the per-beat changeScore/addScore strobes and songDone, and keeps the score (4-digit BCD), combo streak, multiplier and session high score.
- Drives four 7-segment displays with the current score.
- Sits beside the game FSM in the top level; its only downstream load is the HEX displays.

---
 rtl/score_tracker.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_score_tracker.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_tracker.sv
// score_tracker: scoring back end for the rhythm game.
//
// Consumes the game FSM's per-beat judgement strobes and keeps the running
// score (4-digit BCD), the consecutive-hit combo, the derived multiplier and
// the best score since reset. The current score is shown on four
// active-low 7-segment displays.
//
// Ports:
//   clock        system clock
//   reset        asynchronous active-high reset
//   start        one-cycle pulse, begins (or restarts) a song session
//   changeScore  one-cycle strobe, a beat has been judged
//   addScore     qualifies changeScore: 1 = hit, 0 = miss
//   songDone     level or pulse, the song has finished
//   score        current score, BCD, digit 3 in [15:12]
//   highScore    best score since reset, BCD
//   combo        consecutive-hit count, binary, saturates at 255
//   multiplier   points per hit, 1..MAX_MULT, combinational from combo
//   busy         high while a hit's points are being added
//   newHigh      high in DONE when this session set the high score
//   dropped      sticky, a strobe was lost while the pending slot was full
//   HEX3..HEX0   active-low segment drive of score digits 3..0
module score_tracker #(
  parameter int COMBO_STEP = 4,
  parameter int MAX_MULT   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        changeScore,
  input  logic        addScore,
  input  logic        songDone,
  output logic [15:0] score,
  output logic [15:0] highScore,
  output logic [7:0]  combo,
  output logic [2:0]  multiplier,
  output logic        busy,
  output logic        newHigh,
  output logic        dropped,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX0
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  // BCD increment by one with per-digit carry; 9999 holds (saturation).
  function automatic logic [15:0] bcdIncSat(input logic [15:0] value);
    logic [15:0] result;
    logic        carry;
    result = value;
    carry  = 1'b1;
    if (value != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (result[i*4 +: 4] == 4'd9) begin
            result[i*4 +: 4] = 4'd0;
            carry            = 1'b1;
          end else begin
            result[i*4 +: 4] = result[i*4 +: 4] + 4'd1;
            carry            = 1'b0;
          end
        end else begin
          carry = 1'b0;
        end
      end
    end else begin
      result = value;
    end
    return result;
  endfunction

  // Active-low segment code (gfedcba) for one BCD digit; blank otherwise.
  function automatic logic [6:0] segDecode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  state_t      state_r,      stateNext_s;
  logic [15:0] score_r,      scoreNext_s;
  logic [15:0] highScore_r,  highScoreNext_s;
  logic [7:0]  combo_r,      comboNext_s;
  logic [2:0]  addCount_r,   addCountNext_s;
  logic        pendValid_r,  pendValidNext_s;
  logic        pendHit_r,    pendHitNext_s;
  logic        doneSeen_r,   doneSeenNext_s;
  logic        newHigh_r,    newHighNext_s;
  logic        dropped_r,    droppedNext_s;

  logic [8:0]  multRaw_s;
  logic [2:0]  multiplier_s;
  logic        effValid_s;
  logic        effHit_s;
  logic        doneReq_s;

  // Multiplier from the combo streak, clamped to the ceiling.
  always_comb begin
    multRaw_s = 9'd1 + 9'(combo_r / 8'(COMBO_STEP));
    if (multRaw_s > 9'(MAX_MULT)) begin
      multiplier_s = 3'(MAX_MULT);
    end else begin
      multiplier_s = multRaw_s[2:0];
    end
  end

  // Next-state and datapath updates for the session FSM.
  always_comb begin
    stateNext_s     = state_r;
    scoreNext_s     = score_r;
    highScoreNext_s = highScore_r;
    comboNext_s     = combo_r;
    addCountNext_s  = addCount_r;
    pendValidNext_s = pendValid_r;
    pendHitNext_s   = pendHit_r;
    doneSeenNext_s  = doneSeen_r;
    newHighNext_s   = newHigh_r;
    droppedNext_s   = dropped_r;
    effValid_s      = 1'b0;
    effHit_s        = 1'b0;
    doneReq_s       = 1'b0;

    if (start) begin
      // start beats everything, including a coincident strobe.
      stateNext_s     = PLAY;
      scoreNext_s     = 16'h0000;
      comboNext_s     = 8'd0;
      addCountNext_s  = 3'd0;
      pendValidNext_s = 1'b0;
      pendHitNext_s   = 1'b0;
      doneSeenNext_s  = 1'b0;
      newHighNext_s   = 1'b0;
      droppedNext_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          stateNext_s = IDLE;
        end

        PLAY: begin
          doneReq_s = songDone | doneSeen_r;
          // A strobe parked during ADD is served first, as if it arrived
          // now; a strobe arriving this very cycle takes its place.
          if (pendValid_r) begin
            effValid_s      = 1'b1;
            effHit_s        = pendHit_r;
            pendValidNext_s = changeScore;
            pendHitNext_s   = changeScore & addScore;
          end else begin
            effValid_s = changeScore;
            effHit_s   = addScore;
          end

          if (effValid_s && effHit_s) begin
            stateNext_s    = ADD;
            addCountNext_s = multiplier_s;
            doneSeenNext_s = doneReq_s;
            if (combo_r == 8'd255) begin
              comboNext_s = combo_r;
            end else begin
              comboNext_s = combo_r + 8'd1;
            end
          end else begin
            if (effValid_s) begin
              comboNext_s = 8'd0;
            end else begin
              comboNext_s = combo_r;
            end
            // Finish only once nothing is left queued.
            if (doneReq_s && !pendValidNext_s) begin
              stateNext_s = DONE;
            end else begin
              stateNext_s    = PLAY;
              doneSeenNext_s = doneReq_s;
            end
          end
        end

        ADD: begin
          scoreNext_s    = bcdIncSat(score_r);
          addCountNext_s = addCount_r - 3'd1;
          doneSeenNext_s = doneSeen_r | songDone;
          if (changeScore) begin
            if (pendValid_r) begin
              droppedNext_s = 1'b1;
            end else begin
              pendValidNext_s = 1'b1;
              pendHitNext_s   = addScore;
            end
          end else begin
            pendValidNext_s = pendValid_r;
          end
          if (addCount_r <= 3'd1) begin
            if (doneSeenNext_s && !pendValidNext_s) begin
              stateNext_s = DONE;
            end else begin
              stateNext_s = PLAY;
            end
          end else begin
            stateNext_s = ADD;
          end
        end

        DONE: begin
          stateNext_s = DONE;
        end

        default: begin
          stateNext_s = IDLE;
        end
      endcase

      // High-score capture uses the score as it stands after the entry edge.
      if ((stateNext_s == DONE) && (state_r != DONE)) begin
        doneSeenNext_s = 1'b0;
        if (scoreNext_s > highScore_r) begin
          highScoreNext_s = scoreNext_s;
          newHighNext_s   = 1'b1;
        end else begin
          highScoreNext_s = highScore_r;
        end
      end else begin
        highScoreNext_s = highScore_r;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      score_r     <= 16'h0000;
      highScore_r <= 16'h0000;
      combo_r     <= 8'd0;
      addCount_r  <= 3'd0;
      pendValid_r <= 1'b0;
      pendHit_r   <= 1'b0;
      doneSeen_r  <= 1'b0;
      newHigh_r   <= 1'b0;
      dropped_r   <= 1'b0;
    end else begin
      state_r     <= stateNext_s;
      score_r     <= scoreNext_s;
      highScore_r <= highScoreNext_s;
      combo_r     <= comboNext_s;
      addCount_r  <= addCountNext_s;
      pendValid_r <= pendValidNext_s;
      pendHit_r   <= pendHitNext_s;
      doneSeen_r  <= doneSeenNext_s;
      newHigh_r   <= newHighNext_s;
      dropped_r   <= droppedNext_s;
    end
  end

  assign score      = score_r;
  assign highScore  = highScore_r;
  assign combo      = combo_r;
  assign multiplier = multiplier_s;
  assign busy       = (state_r == ADD);
  assign newHigh    = newHigh_r;
  assign dropped    = dropped_r;

  // Displays follow the score register directly.
  assign HEX3 = segDecode(score_r[15:12]);
  assign HEX2 = segDecode(score_r[11:8]);
  assign HEX1 = segDecode(score_r[7:4]);
  assign HEX0 = segDecode(score_r[3:0]);

endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker: table of single-beat vectors with
// a scoreboard queue, plus hand-written sequences for pending strobes,
// high-score sessions, saturation and asynchronous reset.
module tb_score_tracker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        changeScore = 1'b0;
  logic        addScore = 1'b0;
  logic        songDone = 1'b0;
  logic [15:0] score;
  logic [15:0] highScore;
  logic [7:0]  combo;
  logic [2:0]  multiplier;
  logic        busy;
  logic        newHigh;
  logic        dropped;
  logic [6:0]  HEX3, HEX2, HEX1, HEX0;

  int passCount  = 0;
  int checkCount = 0;

  score_tracker #(.COMBO_STEP(4), .MAX_MULT(4)) dut (
    .clock(clock), .reset(reset), .start(start),
    .changeScore(changeScore), .addScore(addScore), .songDone(songDone),
    .score(score), .highScore(highScore), .combo(combo),
    .multiplier(multiplier), .busy(busy), .newHigh(newHigh),
    .dropped(dropped), .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          doStart;
    bit          hit;
    logic [15:0] expScore;
    logic [7:0]  expCombo;
    logic [2:0]  expMult;
    int          expBusy;
  } vec_t;

  vec_t vecs[23];
  vec_t sb[$];

  function automatic vec_t mk(bit s, bit h, logic [15:0] sc, logic [7:0] c,
                              logic [2:0] m, int b);
    vec_t v;
    v.doStart = s; v.hit = h; v.expScore = sc; v.expCombo = c;
    v.expMult = m; v.expBusy = b;
    return v;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] codes [10];
    codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return codes[d];
  endfunction

  function automatic int modelMult(input int c);
    int m;
    m = 1 + c / 4;
    return (m > 4) ? 4 : m;
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, " score"}, score, 32'h0);
    check({tag, " highScore"}, highScore, 32'h0);
    check({tag, " combo"}, combo, 32'd0);
    check({tag, " multiplier"}, multiplier, 32'd1);
    check({tag, " busy"}, busy, 32'd0);
    check({tag, " newHigh"}, newHigh, 32'd0);
    check({tag, " dropped"}, dropped, 32'd0);
    check({tag, " HEX"}, {HEX3, HEX2, HEX1, HEX0}, {4{7'h40}});
  endtask

  task automatic pulseStart();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  // Drive one judged beat, then count busy cycles (bounded).
  task automatic strobe(input bit hit, input bit done, output int busyCycles);
    @(negedge clock);
    changeScore = 1'b1; addScore = hit; songDone = done;
    @(negedge clock);
    changeScore = 1'b0; addScore = 1'b0; songDone = 1'b0;
    busyCycles = 0;
    while (busy && busyCycles < 20) begin
      busyCycles++;
      @(negedge clock);
    end
  endtask

  task automatic pulseDone();
    @(negedge clock); songDone = 1'b1;
    @(negedge clock); songDone = 1'b0;
  endtask

  initial begin
    int   bc;
    int   timeouts;
    int   mScore;
    int   mCombo;
    vec_t exp;

    // Session A: 3 spaced hits. Session B: 5 hits then a miss.
    vecs[0]  = mk(1, 1, 16'h0001, 8'd1, 3'd1, 1);
    vecs[1]  = mk(0, 1, 16'h0002, 8'd2, 3'd1, 1);
    vecs[2]  = mk(0, 1, 16'h0003, 8'd3, 3'd1, 1);
    vecs[3]  = mk(1, 1, 16'h0001, 8'd1, 3'd1, 1);
    vecs[4]  = mk(0, 1, 16'h0002, 8'd2, 3'd1, 1);
    vecs[5]  = mk(0, 1, 16'h0003, 8'd3, 3'd1, 1);
    vecs[6]  = mk(0, 1, 16'h0004, 8'd4, 3'd2, 1);
    vecs[7]  = mk(0, 1, 16'h0006, 8'd5, 3'd2, 2);
    vecs[8]  = mk(0, 0, 16'h0006, 8'd0, 3'd1, 0);
    // Session C: 14 hits, multiplier climbs to the ceiling.
    vecs[9]  = mk(1, 1, 16'h0001, 8'd1,  3'd1, 1);
    vecs[10] = mk(0, 1, 16'h0002, 8'd2,  3'd1, 1);
    vecs[11] = mk(0, 1, 16'h0003, 8'd3,  3'd1, 1);
    vecs[12] = mk(0, 1, 16'h0004, 8'd4,  3'd2, 1);
    vecs[13] = mk(0, 1, 16'h0006, 8'd5,  3'd2, 2);
    vecs[14] = mk(0, 1, 16'h0008, 8'd6,  3'd2, 2);
    vecs[15] = mk(0, 1, 16'h0010, 8'd7,  3'd2, 2);
    vecs[16] = mk(0, 1, 16'h0012, 8'd8,  3'd3, 2);
    vecs[17] = mk(0, 1, 16'h0015, 8'd9,  3'd3, 3);
    vecs[18] = mk(0, 1, 16'h0018, 8'd10, 3'd3, 3);
    vecs[19] = mk(0, 1, 16'h0021, 8'd11, 3'd3, 3);
    vecs[20] = mk(0, 1, 16'h0024, 8'd12, 3'd4, 3);
    vecs[21] = mk(0, 1, 16'h0028, 8'd13, 3'd4, 4);
    vecs[22] = mk(0, 1, 16'h0032, 8'd14, 3'd4, 4);

    #1;
    checkResetValues("power-on reset");
    @(negedge clock); reset = 1'b0;
    // Strobes in IDLE are ignored.
    strobe(1'b1, 1'b0, bc);
    check("idle strobe score", score, 32'h0);
    check("idle strobe busy", bc, 32'd0);

    for (int i = 0; i < 23; i++) begin
      if (vecs[i].doStart) pulseStart();
      sb.push_back(vecs[i]);
      strobe(vecs[i].hit, 1'b0, bc);
      exp = sb.pop_front();
      check($sformatf("vec%0d score", i), score, exp.expScore);
      check($sformatf("vec%0d combo", i), combo, exp.expCombo);
      check($sformatf("vec%0d multiplier", i), multiplier, exp.expMult);
      check($sformatf("vec%0d busy cycles", i), bc, exp.expBusy);
      repeat (8) @(negedge clock);
    end
    check("HEX for 0032", {HEX3, HEX2, HEX1, HEX0},
          {seg(4'd0), seg(4'd0), seg(4'd3), seg(4'd2)});

    // Pending slot: hit then miss during a multiplier-3 ADD.
    pulseStart();
    for (int i = 0; i < 8; i++) strobe(1'b1, 1'b0, bc);
    check("pending pre score", score, 32'h0012);
    check("pending pre multiplier", multiplier, 32'd3);
    @(negedge clock); changeScore = 1'b1; addScore = 1'b1;
    @(negedge clock); addScore = 1'b1;
    @(negedge clock); addScore = 1'b0;
    @(negedge clock); changeScore = 1'b0; addScore = 1'b0;
    check("pending dropped sticky", dropped, 32'd1);
    repeat (10) @(negedge clock);
    check("pending score", score, 32'h0018);
    check("pending combo", combo, 32'd10);
    check("pending dropped", dropped, 32'd1);
    check("pending busy", busy, 32'd0);
    pulseStart();
    check("start clears dropped", dropped, 32'd0);
    check("start clears score", score, 32'h0);

    // High score across two sessions.
    @(negedge clock); reset = 1'b1; #1;
    checkResetValues("sync-point reset");
    @(negedge clock); reset = 1'b0;
    pulseStart();
    for (int i = 0; i < 7; i++) strobe(1'b1, 1'b0, bc);
    check("s1 score", score, 32'h0010);
    pulseDone();
    check("s1 highScore", highScore, 32'h0010);
    check("s1 newHigh", newHigh, 32'd1);
    strobe(1'b1, 1'b0, bc);
    check("done ignores strobe score", score, 32'h0010);
    check("done ignores strobe busy", bc, 32'd0);
    pulseStart();
    check("s2 start clears newHigh", newHigh, 32'd0);
    check("s2 start keeps highScore", highScore, 32'h0010);
    for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0, bc);
    strobe(1'b1, 1'b1, bc);  // hit coincident with songDone
    check("s2 last hit busy", bc, 32'd1);
    repeat (3) @(negedge clock);
    check("s2 score", score, 32'h0004);
    check("s2 combo", combo, 32'd4);
    check("s2 highScore", highScore, 32'h0010);
    check("s2 newHigh", newHigh, 32'd0);
    strobe(1'b1, 1'b0, bc);
    check("s2 in DONE", score, 32'h0004);

    // Saturation: climb to 9974, then miss + 12 hits to 9998 at mult 4.
    pulseStart();
    mScore = 0; mCombo = 0; timeouts = 0;
    while (mScore < 9974) begin
      if ((9974 - mScore) >= modelMult(mCombo)) begin
        strobe(1'b1, 1'b0, bc);
        mScore += modelMult(mCombo);
        mCombo = (mCombo == 255) ? 255 : mCombo + 1;
      end else begin
        strobe(1'b0, 1'b0, bc);
        mCombo = 0;
      end
      if (bc >= 20) timeouts++;
    end
    check("preload timeouts", timeouts, 32'd0);
    check("preload 9974", score, 32'h9974);
    strobe(1'b0, 1'b0, bc);
    for (int i = 0; i < 12; i++) strobe(1'b1, 1'b0, bc);
    check("preload 9998", score, 32'h9998);
    check("preload multiplier", multiplier, 32'd4);
    strobe(1'b1, 1'b0, bc);
    check("saturate busy cycles", bc, 32'd4);
    check("saturate score", score, 32'h9999);
    check("saturate combo", combo, 32'd13);
    check("saturate HEX", {HEX3, HEX2, HEX1, HEX0}, {4{seg(4'd9)}});
    pulseDone();
    check("saturate highScore", highScore, 32'h9999);
    check("saturate newHigh", newHigh, 32'd1);

    // Reset asserted mid-ADD takes effect without a clock edge.
    pulseStart();
    @(negedge clock); changeScore = 1'b1; addScore = 1'b1;
    @(negedge clock); changeScore = 1'b0; addScore = 1'b0;
    check("mid-ADD busy", busy, 32'd1);
    #2 reset = 1'b1;
    #1;
    checkResetValues("async reset mid-ADD");
    @(negedge clock); reset = 1'b0;
    repeat (2) @(negedge clock);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
